// File: rtl/sr_drv_pkg.sv
// Shared encodings for the set/reset latch driver.
// SR_LATCH_DRIVER_ACTIVE_LOW_EN selects active-low S/R drive for NAND-form latches.
package sr_drv_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'b00,
      PULSE = 2'b01,
      GAP   = 2'b10
   } state_t;

   localparam logic CMD_SET   = 1'b1;
   localparam logic CMD_RESET = 1'b0;

`ifdef SR_LATCH_DRIVER_ACTIVE_LOW_EN
   localparam logic DRV_ON  = 1'b0;
   localparam logic DRV_OFF = 1'b1;
`else
   localparam logic DRV_ON  = 1'b1;
   localparam logic DRV_OFF = 1'b0;
`endif

endpackage

// File: rtl/sr_drv_timer.sv
// Loadable down-counter that parks at zero; zero flag is combinational from the count.
module sr_drv_timer #(
   parameter int CW = 3
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          load,
   input  logic [CW-1:0] load_val,
   input  logic          dec,
   output logic          zero
);

   logic [CW-1:0] cnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         cnt <= '0;
      else if (load)
         cnt <= load_val;
      else if (dec && cnt != '0)
         cnt <= cnt - 1'b1;
   end

   assign zero = (cnt == '0);

endmodule

// File: rtl/sr_latch_driver.sv
// Handshaked set/reset command driver producing registered, exclusive S/R pulses with dead time.
// Output polarity follows SR_LATCH_DRIVER_ACTIVE_LOW_EN (see sr_drv_pkg).
module sr_latch_driver
   import sr_drv_pkg::*;
#(
   parameter int PULSE_W = 4,
   parameter int GAP_W   = 2
) (
   input  logic clk,
   input  logic rst_n,
   input  logic req,
   input  logic cmd,
   output logic ready,
   output logic s_out,
   output logic r_out,
   output logic done,
   output logic q_shadow
);

   localparam int MAX_W = (PULSE_W > GAP_W) ? PULSE_W : GAP_W;
   localparam int CW    = $clog2(MAX_W + 1);

   state_t        state;
   logic          cmd_q;
   logic          accept;
   logic          t_zero;
   logic          t_load;
   logic [CW-1:0] t_val;

   assign accept = (state == IDLE) && req && ready;
   assign t_load = accept || ((state == PULSE) && t_zero);
   assign t_val  = (state == IDLE) ? CW'(PULSE_W - 1) : CW'(GAP_W - 1);

   sr_drv_timer #(.CW(CW)) u_timer (
      .clk      (clk),
      .rst_n    (rst_n),
      .load     (t_load),
      .load_val (t_val),
      .dec      (state != IDLE),
      .zero     (t_zero)
   );

   // Drive flops are set on acceptance so the pulse starts the cycle after the accepting edge.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= IDLE;
         cmd_q    <= CMD_RESET;
         ready    <= 1'b1;
         done     <= 1'b0;
         q_shadow <= 1'b0;
         s_out    <= DRV_OFF;
         r_out    <= DRV_OFF;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (accept) begin
                  cmd_q <= cmd;
                  ready <= 1'b0;
                  state <= PULSE;
                  s_out <= (cmd == CMD_SET)   ? DRV_ON : DRV_OFF;
                  r_out <= (cmd == CMD_RESET) ? DRV_ON : DRV_OFF;
               end
            end
            PULSE: begin
               if (t_zero) begin
                  state    <= GAP;
                  s_out    <= DRV_OFF;
                  r_out    <= DRV_OFF;
                  q_shadow <= cmd_q;
               end
            end
            GAP: begin
               if (t_zero) begin
                  state <= IDLE;
                  ready <= 1'b1;
                  done  <= 1'b1;
               end
            end
            default: begin
               state <= IDLE;
               ready <= 1'b1;
               s_out <= DRV_OFF;
               r_out <= DRV_OFF;
            end
         endcase
      end
   end

endmodule
